// File: rtl/nfc_spi_pkg.sv
// rtl/nfc_spi_pkg.sv - shared control codes, status bits and state encoding for the NFC SPI link
package nfc_spi_pkg;

    localparam logic [7:0] CTRL_SEND     = 8'h00;
    localparam logic [7:0] CTRL_READ_ALT = 8'h01;
    localparam logic [7:0] CTRL_READ     = 8'h02;
    localparam logic [7:0] CTRL_POLL     = 8'h03;

    localparam int STATUS_RDY_BIT = 3;
    localparam int STATUS_CMD_BIT = 2;

    localparam logic [2:0] ST_SLEEP   = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_CTRL    = 3'd2;
    localparam logic [2:0] ST_CMD_RX  = 3'd3;
    localparam logic [2:0] ST_POLL_TX = 3'd4;
    localparam logic [2:0] ST_READ_TX = 3'd5;
    localparam logic [2:0] ST_DISCARD = 3'd6;

    function automatic logic [7:0] status_byte(input logic rdy);
        logic [7:0] s;
        s                 = '0;
        s[STATUS_RDY_BIT] = rdy;
        s[STATUS_CMD_BIT] = ~rdy;
        return s;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - 2-FF synchronisers and edge strobes for the async SPI/IRQ pins
module spi_slave_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs,
    input  logic mosi,
    input  logic irq_in,
    output logic mosi_s,
    output logic irq_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic irq_rise
);

    // [0] metastable stage, [1] synchronised value, [2] previous value for edges
    logic [2:0] sck_q, cs_q, irq_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            irq_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            cs_q   <= {cs_q[1:0], cs};
            irq_q  <= {irq_q[1:0], irq_in};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign mosi_s   = mosi_q[1];
    assign irq_s    = irq_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign irq_rise = irq_q[1] & ~irq_q[2];

endmodule

// File: rtl/nfc_spi_responder.sv
// rtl/nfc_spi_responder.sv - SPI mode-0 slave emulating the NFC front-end serial port
module nfc_spi_responder
    import nfc_spi_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WAKE_MIN = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic       IRQ_IN,
    output logic       IRQ_OUT,
    output logic       awake,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    input  logic       rsp_wr_en,
    input  logic [7:0] rsp_wr_data,
    input  logic [7:0] rsp_code,
    input  logic       rsp_commit,
    output logic       rsp_ready,
    output logic       ctrl_err
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int WAKE_W = $clog2(WAKE_MIN + 1);

    logic mosi_s, irq_s, sck_rise, sck_fall, cs_fall, cs_rise, irq_rise;

    spi_slave_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .irq_in   (IRQ_IN),
        .mosi_s   (mosi_s),
        .irq_s    (irq_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .irq_rise (irq_rise)
    );

    logic [2:0]        state_q, state_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              awake_q, awake_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [7:0]        out_idx_q, out_idx_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              rd_live_q, rd_live_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     len_q, len_d;
    logic [7:0]        code_q, code_d;
    logic              rdy_q, rdy_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    logic              ctrl_err_q, ctrl_err_d;
    logic              irq_out_q, irq_out_d;

    logic [7:0] mem [DEPTH];
    logic [7:0] rx_byte;
    logic       wr_ok;

    assign rx_byte = {rx_q, mosi_s};
    assign wr_ok   = rsp_wr_en && !rdy_q && (cnt_q != CW'(DEPTH));

    always_comb begin
        state_d     = state_q;
        wake_cnt_d  = wake_cnt_q;
        awake_d     = awake_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        out_idx_d   = out_idx_q;
        rd_ptr_d    = rd_ptr_q;
        rd_live_d   = rd_live_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        code_d      = code_q;
        rdy_d       = rdy_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;
        ctrl_err_d  = 1'b0;

        // A write in the same cycle as a commit is counted in len.
        if (wr_ok) cnt_d = cnt_q + CW'(1);
        if (rsp_commit && !rdy_q) begin
            rdy_d  = 1'b1;
            code_d = rsp_code;
            len_d  = wr_ok ? cnt_q + CW'(1) : cnt_q;
        end

        case (state_q)
            ST_SLEEP: begin
                if (!irq_s) begin
                    if (wake_cnt_q != WAKE_W'(WAKE_MIN)) wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end else begin
                    wake_cnt_d = '0;
                    if (irq_rise && wake_cnt_q == WAKE_W'(WAKE_MIN)) begin
                        awake_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CTRL;
                    bit_cnt_d = '0;
                    out_idx_d = '0;
                    rd_ptr_d  = '0;
                    tx_d      = '0;
                end
            end
            default: begin
                if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sck_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // Byte boundary: the next output byte is staged for the following fall.
                    if (bit_cnt_q == 3'd7) begin
                        case (state_q)
                            ST_CTRL: begin
                                if (rx_byte == CTRL_SEND) begin
                                    state_d = ST_CMD_RX;
                                    tx_d    = '0;
                                end else if (rx_byte == CTRL_POLL) begin
                                    state_d = ST_POLL_TX;
                                    tx_d    = status_byte(rdy_q);
                                end else if (rx_byte == CTRL_READ || rx_byte == CTRL_READ_ALT) begin
                                    state_d   = ST_READ_TX;
                                    tx_d      = code_q;
                                    rd_live_d = rdy_q;
                                end else begin
                                    state_d    = ST_DISCARD;
                                    tx_d       = '0;
                                    ctrl_err_d = 1'b1;
                                end
                            end
                            ST_CMD_RX: begin
                                cmd_valid_d = 1'b1;
                                cmd_byte_d  = rx_byte;
                            end
                            ST_POLL_TX: tx_d = status_byte(rdy_q);
                            ST_READ_TX: begin
                                if (out_idx_q != 8'hFF) out_idx_d = out_idx_q + 8'd1;
                                if (out_idx_q == 8'd0) begin
                                    tx_d = rd_live_q ? 8'(len_q) : 8'h00;
                                end else if (rd_live_q && (out_idx_q - 8'd1) < 8'(len_q)) begin
                                    tx_d     = mem[rd_ptr_q];
                                    rd_ptr_d = rd_ptr_q + PW'(1);
                                end else begin
                                    tx_d = '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    miso_d    = 1'b0;
                    tx_d      = '0;
                    bit_cnt_d = '0;
                    // The response is consumed only once the len byte has gone out.
                    if (state_q == ST_READ_TX && rd_live_q && out_idx_q >= 8'd2) begin
                        rdy_d  = 1'b0;
                        cnt_d  = '0;
                        len_d  = '0;
                        code_d = '0;
                    end
                end
            end
        endcase

        irq_out_d = ~(rdy_d && state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SLEEP;
            wake_cnt_q  <= '0;
            awake_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            out_idx_q   <= '0;
            rd_ptr_q    <= '0;
            rd_live_q   <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            code_q      <= '0;
            rdy_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
            ctrl_err_q  <= 1'b0;
            irq_out_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            awake_q     <= awake_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            out_idx_q   <= out_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_live_q   <= rd_live_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            code_q      <= code_d;
            rdy_q       <= rdy_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            ctrl_err_q  <= ctrl_err_d;
            irq_out_q   <= irq_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[cnt_q[PW-1:0]] <= rsp_wr_data;
    end

    assign miso      = miso_q;
    assign IRQ_OUT   = irq_out_q;
    assign awake     = awake_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;
    assign rsp_ready = rdy_q;
    assign ctrl_err  = ctrl_err_q;

endmodule

// File: tb/tb_nfc_spi_responder.sv
// tb/tb_nfc_spi_responder.sv - self-checking bench for nfc_spi_responder
module tb_nfc_spi_responder;

    localparam int DEPTH    = 16;
    localparam int WAKE_MIN = 256;
    localparam int HALF     = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       IRQ_IN = 1'b1;
    logic       rsp_wr_en = 1'b0;
    logic       rsp_commit = 1'b0;
    logic [7:0] rsp_wr_data = '0;
    logic [7:0] rsp_code = '0;
    logic       miso, IRQ_OUT, awake, cmd_valid, rsp_ready, ctrl_err;
    logic [7:0] cmd_byte;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nfc_spi_responder #(.DEPTH(DEPTH), .WAKE_MIN(WAKE_MIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .IRQ_IN      (IRQ_IN),
        .IRQ_OUT     (IRQ_OUT),
        .awake       (awake),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .rsp_wr_en   (rsp_wr_en),
        .rsp_wr_data (rsp_wr_data),
        .rsp_code    (rsp_code),
        .rsp_commit  (rsp_commit),
        .rsp_ready   (rsp_ready),
        .ctrl_err    (ctrl_err)
    );

    logic [7:0] cmd_seen [$];
    int         err_pulses = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) cmd_seen.push_back(cmd_byte);
            if (ctrl_err) err_pulses++;
        end
    end

    // Reference model of the response buffer as seen by the host side
    logic [7:0] m_buf [$];
    bit         m_rdy = 1'b0;
    logic [7:0] m_code = '0;
    int         m_len = 0;

    logic [7:0] tx_bytes [$];
    logic [7:0] rx_bytes [$];

    function automatic logic [7:0] exp_read(input int j);
        if (!m_rdy) return 8'h00;
        if (j == 0) return m_code;
        if (j == 1) return 8'(m_len);
        if (j - 2 < m_len) return m_buf[j-2];
        return 8'h00;
    endfunction

    task automatic shift_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = '0;
        for (int k = 0; k < nbits; k++) begin
            mosi = b[7-k];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            r = {r[6:0], miso};
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame();
        logic [7:0] r;
        rx_bytes = {};
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (IRQ_OUT !== 1'b1) begin
            errors++;
            $display("FAIL irq_out_cs_fall got %b want 1", IRQ_OUT);
        end
        repeat (HALF) @(negedge clk);
        foreach (tx_bytes[i]) begin
            shift_byte(tx_bytes[i], 8, r);
            rx_bytes.push_back(r);
        end
        repeat (HALF) @(negedge clk);
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL miso_cs_high got %b want 0", miso);
        end
    endtask

    task automatic bus_write(input logic [7:0] d, input bit commit, input logic [7:0] code);
        @(negedge clk);
        rsp_wr_en = 1'b1; rsp_wr_data = d; rsp_commit = commit; rsp_code = code;
        @(negedge clk);
        rsp_wr_en = 1'b0; rsp_commit = 1'b0;
        if (!m_rdy && m_buf.size() < DEPTH) m_buf.push_back(d);
        if (commit && !m_rdy) begin
            m_rdy = 1'b1; m_code = code; m_len = m_buf.size();
        end
    endtask

    task automatic bus_commit(input logic [7:0] code);
        @(negedge clk);
        rsp_commit = 1'b1; rsp_code = code;
        @(negedge clk);
        rsp_commit = 1'b0;
        if (!m_rdy) begin
            m_rdy = 1'b1; m_code = code; m_len = m_buf.size();
        end
    endtask

    task automatic check_ready(input string name);
        checks++;
        if (rsp_ready !== m_rdy) begin
            errors++;
            $display("FAIL %s rsp_ready got %b want %b", name, rsp_ready, m_rdy);
        end
        checks++;
        if (IRQ_OUT !== !m_rdy) begin
            errors++;
            $display("FAIL %s IRQ_OUT got %b want %b", name, IRQ_OUT, !m_rdy);
        end
    endtask

    task automatic do_read(input int n, input string name);
        logic [7:0] want [$];
        want = {};
        for (int j = 0; j < n - 1; j++) want.push_back(exp_read(j));
        tx_bytes = {($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02};
        for (int j = 1; j < n; j++) tx_bytes.push_back(8'($urandom));
        spi_frame();
        for (int j = 1; j < n; j++) begin
            checks++;
            if (rx_bytes[j] !== want[j-1]) begin
                errors++;
                $display("FAIL %s byte %0d got %h want %h", name, j, rx_bytes[j], want[j-1]);
            end
        end
        if (m_rdy && n >= 3) begin
            m_rdy = 1'b0; m_buf = {}; m_len = 0; m_code = '0;
        end
        check_ready(name);
    endtask

    task automatic do_poll(input int n, input string name);
        logic [7:0] want;
        want = m_rdy ? 8'h08 : 8'h04;
        tx_bytes = {8'h03};
        for (int j = 1; j < n; j++) tx_bytes.push_back(8'($urandom));
        spi_frame();
        for (int j = 1; j < n; j++) begin
            checks++;
            if (rx_bytes[j] !== want) begin
                errors++;
                $display("FAIL %s byte %0d got %h want %h", name, j, rx_bytes[j], want);
            end
        end
    endtask

    task automatic do_send(input string name);
        int e0;
        e0 = err_pulses;
        cmd_seen = {};
        spi_frame();
        repeat (4) @(negedge clk);
        checks++;
        if (cmd_seen.size() !== tx_bytes.size() - 1) begin
            errors++;
            $display("FAIL %s cmd_count got %0d want %0d", name, cmd_seen.size(), tx_bytes.size() - 1);
        end else begin
            for (int j = 1; j < tx_bytes.size(); j++) begin
                checks++;
                if (cmd_seen[j-1] !== tx_bytes[j]) begin
                    errors++;
                    $display("FAIL %s cmd %0d got %h want %h", name, j - 1, cmd_seen[j-1], tx_bytes[j]);
                end
            end
        end
        checks++;
        if (err_pulses !== e0) begin
            errors++;
            $display("FAIL %s ctrl_err got %0d want %0d", name, err_pulses - e0, 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [15:0] got;
        got = {miso, IRQ_OUT, awake, cmd_valid, cmd_byte, rsp_ready, ctrl_err, 2'b00};
        checks++;
        if (got !== 16'b0_1_0_0_00000000_0_0_00) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, got, 16'b0_1_0_0_00000000_0_0_00);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_wake();
        IRQ_IN = 1'b0;
        repeat (100) @(negedge clk);
        IRQ_IN = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (awake !== 1'b0) begin
            errors++;
            $display("FAIL wake_short got %b want 0", awake);
        end
        IRQ_IN = 1'b0;
        repeat (300) @(negedge clk);
        IRQ_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (awake !== 1'b1) begin
            errors++;
            $display("FAIL wake_long got %b want 1", awake);
        end
    endtask

    task automatic test_send();
        tx_bytes = {8'h00, 8'h04, 8'h00, 8'h01, 8'h00};
        do_send("send_directed");
        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(1, 5);
            tx_bytes = {8'h00};
            for (int j = 0; j < n; j++) tx_bytes.push_back(8'($urandom));
            do_send("send_random");
        end
    endtask

    task automatic test_poll();
        do_poll(3, "poll_empty");
        bus_write(8'hA1, 1'b0, 8'h00);
        bus_write(8'hB2, 1'b0, 8'h00);
        bus_write(8'hC3, 1'b0, 8'h00);
        bus_commit(8'h80);
        check_ready("commit_directed");
        do_poll(3, "poll_ready");
        check_ready("poll_ready_after");
    endtask

    task automatic test_read();
        logic [7:0] lit [5];
        lit = '{8'h80, 8'h03, 8'hA1, 8'hB2, 8'hC3};
        do_read(6, "read_directed");
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (rx_bytes[j+1] !== lit[j]) begin
                errors++;
                $display("FAIL read_literal byte %0d got %h want %h", j, rx_bytes[j+1], lit[j]);
            end
        end
        do_read(3, "read_after_clear");
    endtask

    task automatic test_read_abort();
        bus_write(8'hA1, 1'b0, 8'h00);
        bus_write(8'hB2, 1'b0, 8'h00);
        bus_write(8'hC3, 1'b0, 8'h00);
        bus_commit(8'h80);
        do_read(2, "read_abort");
        do_read(6, "read_after_abort");
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int         nwr;
            bit         same;
            logic [7:0] code;
            nwr  = (it == 0) ? 0 : int'($urandom_range(1, DEPTH + 2));
            code = 8'($urandom);
            same = ($urandom_range(0, 1) == 1) && (nwr > 0);
            for (int k = 0; k < nwr; k++) bus_write(8'($urandom), same && (k == nwr - 1), code);
            if (!same) bus_commit(code);
            bus_write(8'($urandom), 1'b1, ~code);
            check_ready("commit_random");
            do_poll(2, "poll_random");
            do_read($urandom_range(2, m_len + 4), "read_random");
            if (m_rdy) do_read(m_len + 3 + int'($urandom_range(0, 2)), "read_random_full");
        end
    endtask

    task automatic test_bad_ctrl();
        for (int it = 0; it < 2; it++) begin
            int e0;
            e0 = err_pulses;
            cmd_seen = {};
            tx_bytes = {(it == 0) ? 8'h55 : 8'($urandom_range(4, 255)), 8'($urandom), 8'($urandom)};
            spi_frame();
            checks++;
            if (err_pulses !== e0 + 1) begin
                errors++;
                $display("FAIL bad_ctrl_err got %0d want %0d", err_pulses - e0, 1);
            end
            checks++;
            if (cmd_seen.size() !== 0) begin
                errors++;
                $display("FAIL bad_ctrl_cmd got %0d want %0d", cmd_seen.size(), 0);
            end
            for (int j = 1; j < 3; j++) begin
                checks++;
                if (rx_bytes[j] !== 8'h00) begin
                    errors++;
                    $display("FAIL bad_ctrl_miso byte %0d got %h want %h", j, rx_bytes[j], 8'h00);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        bus_write(8'h5A, 1'b0, 8'h00);
        bus_commit(8'h80);
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
        shift_byte(8'h02, 8, r);
        repeat (5) @(negedge clk);
        checks++;
        if (miso !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_miso got %b want 1", miso);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_read");
        cs = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_rdy = 1'b0; m_buf = {}; m_len = 0; m_code = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_after_mid_read");
    endtask

    initial begin
        test_reset();
        test_wake();
        test_send();
        test_poll();
        test_read();
        test_read_abort();
        test_random();
        test_bad_ctrl();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
